// File: rtl/cordic_share_ctrl.sv
// Time-multiplexes one shared CORDIC core between two operands: issues x_one,
// waits for its result, then issues x_two, with a per-operand wait timeout.
`timescale 1ns/1ps
module cordic_share_ctrl #(
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_two,
  output logic                         cordic_start,
  output logic [CORDIC_DATA_WIDTH-1:0] cordic_x,
  input  logic                         cordic_done,
  input  logic [CORDIC_DATA_WIDTH-1:0] cordic_result,
  output logic [CORDIC_DATA_WIDTH-1:0] out_one,
  output logic [CORDIC_DATA_WIDTH-1:0] out_two,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE_ONE = 3'd1;
  localparam logic [2:0] S_WAIT_ONE  = 3'd2;
  localparam logic [2:0] S_ISSUE_TWO = 3'd3;
  localparam logic [2:0] S_WAIT_TWO  = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CORDIC_DATA_WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [CORDIC_DATA_WIDTH-1:0] cx_q, cx_d, out1_q, out1_d, out2_q, out2_d;
  logic                         cstart_q, cstart_d, done_q, done_d, err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    cx_d     = cx_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    err_d    = err_q;
    cstart_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x1_d     = x_one;
          x2_d     = x_two;
          err_d    = 1'b0;
          cx_d     = x_one;
          cstart_d = 1'b1;
          state_d  = S_ISSUE_ONE;
        end
      end
      S_ISSUE_ONE: begin
        cnt_d   = '0;
        state_d = S_WAIT_ONE;
      end
      S_WAIT_ONE: begin
        // A result arriving on the timeout cycle wins over the timeout.
        if (cordic_done || cnt_q == TMO) begin
          if (cordic_done) begin
            out1_d = cordic_result;
          end else begin
            out1_d = '0;
            err_d  = 1'b1;
          end
          cx_d     = x2_q;
          cstart_d = 1'b1;
          state_d  = S_ISSUE_TWO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ISSUE_TWO: begin
        cnt_d   = '0;
        state_d = S_WAIT_TWO;
      end
      S_WAIT_TWO: begin
        if (cordic_done || cnt_q == TMO) begin
          if (cordic_done) begin
            out2_d = cordic_result;
          end else begin
            out2_d = '0;
            err_d  = 1'b1;
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      cx_q     <= '0;
      out1_q   <= '0;
      out2_q   <= '0;
      cstart_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      cx_q     <= cx_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      cstart_q <= cstart_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cordic_start = cstart_q;
  assign cordic_x     = cx_q;
  assign out_one      = out1_q;
  assign out_two      = out2_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = err_q;

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Bench for cordic_share_ctrl: a latency-programmable CORDIC stub returning x+1
// and a scoreboard of expected results compared when done pulses.
`timescale 1ns/1ps
module tb_cordic_share_ctrl;
  localparam int W = 22;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst, clk_en, start;
  logic [W-1:0] x_one, x_two, cordic_x, out_one, out_two;
  logic [W-1:0] cordic_result = '0;
  logic         cordic_done = 1'b0;
  logic         cordic_start, busy, done, error;

  always #5 clk = ~clk;

  cordic_share_ctrl #(.CORDIC_DATA_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .x_one(x_one), .x_two(x_two),
    .cordic_start(cordic_start), .cordic_x(cordic_x),
    .cordic_done(cordic_done), .cordic_result(cordic_result),
    .out_one(out_one), .out_two(out_two),
    .busy(busy), .done(done), .error(error)
  );

  // Stub core: latency lat_one for operand key_one, lat_two otherwise; 0 = never answers.
  int           lat_one = 4, lat_two = 4;
  logic [W-1:0] key_one = '0;
  int           stub_lat, stub_rem = 0;
  logic         stub_pend = 1'b0;
  logic [W-1:0] stub_res = '0;

  always_comb stub_lat = (cordic_x == key_one) ? lat_one : lat_two;

  always @(posedge clk) begin
    if (clk_en) begin
      cordic_done <= 1'b0;
      if (cordic_start) begin
        if (stub_lat <= 0) begin
          stub_pend <= 1'b0;
        end else if (stub_lat == 1) begin
          cordic_done   <= 1'b1;
          cordic_result <= cordic_x + 1'b1;
          stub_pend     <= 1'b0;
        end else begin
          stub_pend <= 1'b1;
          stub_rem  <= stub_lat - 1;
          stub_res  <= cordic_x + 1'b1;
        end
      end else if (stub_pend) begin
        if (stub_rem == 1) begin
          cordic_done   <= 1'b1;
          cordic_result <= stub_res;
          stub_pend     <= 1'b0;
        end else begin
          stub_rem <= stub_rem - 1;
        end
      end
    end
  end

  typedef struct {
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic         err;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outcome of one transaction; cyc is the clock edge (counted from the
  // accepting edge) at which done is first seen high.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int l1, input int l2, input int stall);
    exp_t e;
    logic ok1, ok2;
    int   w1, w2;
    ok1 = (l1 >= 1) && (l1 <= T + 1);
    ok2 = (l2 >= 1) && (l2 <= T + 1);
    w1 = ok1 ? l1 : T + 1;
    w2 = ok2 ? l2 : T + 1;
    e.o1  = ok1 ? a + 1'b1 : '0;
    e.o2  = ok2 ? b + 1'b1 : '0;
    e.err = !(ok1 && ok2);
    e.cyc = 3 + w1 + w2 + stall;
    sbq.push_back(e);
  endtask

  task automatic run_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int l1, input int l2, input int stall_at, input int stall_len);
    exp_t e;
    int   cyc, nst;
    logic got;
    key_one = a; lat_one = l1; lat_two = l2;
    push_exp(a, b, l1, l2, stall_len);
    @(negedge clk);
    x_one = a; x_two = b; start = 1'b1;
    cyc = 0; nst = 0; got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      if (cordic_start) nst++;
      if (cyc == 1) begin
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || error !== 1'b0) begin
          n_bad++;
          $display("FAIL %s accept: busy=%b error=%b, required busy=1 error=0", name, busy, error);
        end
      end
      if (stall_len > 0 && cyc == stall_at) clk_en = 1'b0;
      if (stall_len > 0 && cyc == stall_at + stall_len) clk_en = 1'b1;
    end
    clk_en = 1'b1;
    e = sbq.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s no_done: done never seen in %0d cycles, required at cycle %0d", name, cyc, e.cyc);
      return;
    end
    n_cmp++;
    if (cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d, required %0d", name, cyc, e.cyc);
    end
    n_cmp++;
    if (out_one !== e.o1 || out_two !== e.o2 || error !== e.err) begin
      n_bad++;
      $display("FAIL %s results: out_one=%h out_two=%h error=%b, required %h %h %b",
               name, out_one, out_two, error, e.o1, e.o2, e.err);
    end
    n_cmp++;
    if (nst !== 2) begin
      n_bad++;
      $display("FAIL %s issues: %0d cordic_start pulses, required 2", name, nst);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || out_one !== e.o1 || out_two !== e.o2 || error !== e.err) begin
      n_bad++;
      $display("FAIL %s after_done: done=%b busy=%b out_one=%h out_two=%h error=%b, required 0 0 %h %h %b",
               name, done, busy, out_one, out_two, error, e.o1, e.o2, e.err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clk_en = 1'b0; start = 1'b1; x_one = '1; x_two = '1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cordic_start, busy, done, error} !== 4'b0 || cordic_x !== '0 || out_one !== '0 || out_two !== '0) begin
      n_bad++;
      $display("FAIL reset: cs=%b busy=%b done=%b err=%b cx=%h o1=%h o2=%h, required all 0",
               cordic_start, busy, done, error, cordic_x, out_one, out_two);
    end
    start = 1'b0; clk_en = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    run_txn("basic", 22'h00100, 22'h00200, 4, 4, 0, 0);
  endtask

  task automatic test_patterns();
    run_txn("lat1", 22'h3FFFFF, 22'h000000, 1, 1, 0, 0);
    run_txn("lat7_2", 22'h155555, 22'h2AAAAA, 7, 2, 0, 0);
    for (int unsigned i = 0; i < 3; i++)
      run_txn("rand", W'($urandom), W'($urandom) | 22'h1, int'($urandom_range(1, 9)),
              int'($urandom_range(1, 9)), 0, 0);
  endtask

  task automatic test_stall();
    run_txn("stall", 22'h00100, 22'h00200, 4, 4, 3, 5);
  endtask

  task automatic test_timeout();
    run_txn("timeout_two", 22'h00333, 22'h00444, 4, 0, 0, 0);
    run_txn("err_clear", 22'h00555, 22'h00666, 4, 4, 0, 0);
    run_txn("timeout_one", 22'h00777, 22'h00888, 0, 3, 0, 0);
  endtask

  task automatic test_boundary_latency();
    run_txn("lat64", 22'h01000, 22'h02000, T, 2, 0, 0);
    run_txn("lat65_coincide", 22'h03000, 22'h04000, T + 1, T + 1, 0, 0);
    run_txn("lat66_timeout", 22'h05000, 22'h06000, 2, T + 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc, nst, ndone, first_cyc;
    key_one = 22'h00AA0; lat_one = 4; lat_two = 4;
    push_exp(22'h00AA0, 22'h00BB0, 4, 4, 0);
    push_exp(22'h00CC0, 22'h00DD0, 4, 4, 12);
    @(negedge clk);
    x_one = 22'h00AA0; x_two = 22'h00BB0; start = 1'b1;
    nst = 0; ndone = 0; first_cyc = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cordic_start) nst++;
      if (cyc == 3) begin
        x_one = 22'h00CC0; x_two = 22'h00DD0;
      end
      if (cyc == 12) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b idle_gap: busy=%b at cycle 12, required 0", busy);
        end
      end
      if (cyc == 20) start = 1'b0;
      if (done) begin
        ndone++;
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b2b extra_done: unexpected done at cycle %0d, required none", cyc);
        end else begin
          e = sbq.pop_front();
          n_cmp++;
          if (cyc !== e.cyc || out_one !== e.o1 || out_two !== e.o2 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b result: cycle %0d out_one=%h out_two=%h error=%b, required cycle %0d %h %h 0",
                     cyc, out_one, out_two, error, e.cyc, e.o1, e.o2);
          end
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (ndone !== 2 || nst !== 4) begin
      n_bad++;
      $display("FAIL b2b counts: done=%0d issues=%0d, required 2 and 4", ndone, nst);
    end
    sbq.delete();
  endtask

  task automatic test_mid_reset();
    int ndone, ncd;
    key_one = 22'h00010; lat_one = 4; lat_two = 4;
    @(negedge clk);
    x_one = 22'h00010; x_two = 22'h00020; start = 1'b1;
    ndone = 0; ncd = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 8) rst = 1'b0;
      if (cyc == 9) begin
        n_cmp++;
        if ({cordic_start, busy, done, error} !== 4'b0 || cordic_x !== '0 || out_one !== '0 || out_two !== '0) begin
          n_bad++;
          $display("FAIL mid_reset clear: cs=%b busy=%b done=%b err=%b cx=%h o1=%h o2=%h, required all 0",
                   cordic_start, busy, done, error, cordic_x, out_one, out_two);
        end
        rst = 1'b1;
      end
      if (cyc >= 9 && done) ndone++;
      if (cyc >= 9 && cordic_done) ncd++;
    end
    n_cmp++;
    if (ndone !== 0 || busy !== 1'b0 || ncd !== 1) begin
      n_bad++;
      $display("FAIL mid_reset late_done: done pulses=%0d busy=%b stub dones=%0d, required 0 0 1", ndone, busy, ncd);
    end
    run_txn("after_reset", 22'h00030, 22'h00040, 3, 3, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_stall();
    test_timeout();
    test_boundary_latency();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

endmodule
